// File: rtl/exec_ctrl_pkg.sv
// Shared types and constants for the run/halt/step sequencer of the RV32I core.
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_HOST     = 3'd1,
        CAUSE_BP       = 3'd2,
        CAUSE_EBREAK   = 3'd3,
        CAUSE_WATCHDOG = 3'd4
    } halt_cause_t;

    localparam logic [31:0] EBREAK_INST       = 32'h0010_0073;
    localparam logic [31:0] MAX_INSTR_DEFAULT = 32'd100000;

endpackage

// File: rtl/exec_cnt.sv
// 32-bit wrapping event counter; a clear takes priority over an increment.
module exec_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/step sequencer: gates every architectural commit of the core through core_en
// and halts on host request, EBREAK, PC breakpoint or retired-instruction watchdog.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter logic [31:0] MAX_INSTR   = exec_ctrl_pkg::MAX_INSTR_DEFAULT,
    parameter logic [31:0] EBREAK_INST = exec_ctrl_pkg::EBREAK_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        clr_cnt,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        core_en,
    output logic        running,
    output logic        halted,
    output logic [2:0]  halt_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    state_t      state_q, state_d;
    halt_cause_t halt_cause_q, halt_cause_d;
    logic        skip_bp_q, skip_bp_d;

    logic is_ebreak;
    logic bp_hit;
    logic wd_hit;

    assign is_ebreak = (inst == EBREAK_INST);
    assign bp_hit    = bp_en && (pc == bp_addr) && !skip_bp_q;
    assign wd_hit    = (MAX_INSTR != 32'd0) && ((instret_cnt + 32'd1) == MAX_INSTR);

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        skip_bp_d    = skip_bp_q;
        core_en      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                // skip_bp lets a resume from a breakpoint PC commit that instruction once
                if (start) begin
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    skip_bp_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = CAUSE_HOST;
                end else if (is_ebreak) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = CAUSE_EBREAK;
                end else if (bp_hit) begin
                    state_d      = ST_HALTED;
                    halt_cause_d = CAUSE_BP;
                end else begin
                    core_en   = 1'b1;
                    skip_bp_d = 1'b0;
                    if (wd_hit) begin
                        state_d      = ST_HALTED;
                        halt_cause_d = CAUSE_WATCHDOG;
                    end
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
                if (is_ebreak) begin
                    halt_cause_d = CAUSE_EBREAK;
                end else begin
                    core_en      = 1'b1;
                    skip_bp_d    = 1'b0;
                    halt_cause_d = CAUSE_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            halt_cause_q <= CAUSE_NONE;
            skip_bp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            skip_bp_q    <= skip_bp_d;
        end
    end

    assign running    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign halted     = (state_q == ST_HALTED);
    assign halt_cause = halt_cause_q;

    exec_cnt u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_cnt),
        .inc_i (running),
        .cnt_o (cycle_cnt)
    );

    exec_cnt u_instret_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr_cnt),
        .inc_i (core_en),
        .cnt_o (instret_cnt)
    );

endmodule
